// File: rtl/riscv_pkg.sv
// RV32I opcode map, instruction-type and skid-buffer state types shared by the decode slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_L   = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_J   = 7'b1101111;
   localparam logic [6:0] OP_JR  = 7'b1100111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;

   localparam int NUM_TYPES = 9;

   // Enum value doubles as the strobe bit index; IT_ILLEGAL has no strobe.
   typedef enum logic [3:0] {
      IT_R, IT_I, IT_L, IT_S, IT_B, IT_J, IT_JR, IT_LUI, IT_AUI, IT_ILLEGAL
   } instr_type_e;

   typedef enum logic [1:0] {
      BUF_EMPTY, BUF_ONE, BUF_TWO
   } buf_state_e;

   // One buffered beat: decode result travels with the raw word and its PC.
   typedef struct packed {
      logic [NUM_TYPES-1:0] str;
      logic                 illegal;
      logic [31:0]          instr;
      logic [31:0]          pc;
   } beat_t;

   function automatic instr_type_e classify(input logic [6:0] op);
      instr_type_e t;
      case (op)
         OP_R:    t = IT_R;
         OP_I:    t = IT_I;
         OP_L:    t = IT_L;
         OP_S:    t = IT_S;
         OP_B:    t = IT_B;
         OP_J:    t = IT_J;
         OP_JR:   t = IT_JR;
         OP_LUI:  t = IT_LUI;
         OP_AUI:  t = IT_AUI;
         default: t = IT_ILLEGAL;
      endcase
      // Compressed-encoding space is never legal here.
      if (op[1:0] != 2'b11) t = IT_ILLEGAL;
      return t;
   endfunction

endpackage

// File: rtl/opcode_onehot.sv
// Combinational opcode to one-hot type strobes plus illegal flag.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module opcode_onehot
   import riscv_pkg::*;
(
   input  logic [6:0]           opcode,
   output logic [NUM_TYPES-1:0] strobes,
   output logic                 illegal
);

   instr_type_e t;

   // Exactly one strobe for a recognised opcode, otherwise only illegal.
   always_comb begin
      t       = classify(opcode);
      strobes = '0;
      illegal = 1'b0;
      if (t == IT_ILLEGAL) illegal = 1'b1;
      else                 strobes[t] = 1'b1;
   end

endmodule

// File: rtl/instr_type_decode.sv
// Decodes RV32I instruction type on entry and buffers beats in a 2-entry skid FIFO.
// Latency: one cycle from accepted input beat to out_valid when empty.
// Backpressure: registered in_ready drops only when both entries are full; held output stays stable.
module instr_type_decode
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        R,
   output logic        I,
   output logic        L,
   output logic        S,
   output logic        B,
   output logic        J,
   output logic        Jr,
   output logic        lui,
   output logic        aui,
   output logic        illegal,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc
);

   logic [NUM_TYPES-1:0] in_str;
   logic                 in_ill;
   beat_t                in_beat;

   buf_state_e state_q, state_d;
   beat_t      head_q, head_d;   // entry presented on out_*
   beat_t      skid_q, skid_d;   // second entry, filled only while head is stalled
   logic       in_ready_q, in_ready_d;
   logic       push, pop;

   opcode_onehot u_onehot (
      .opcode  (in_instr[6:0]),
      .strobes (in_str),
      .illegal (in_ill)
   );

   assign in_beat   = '{str: in_str, illegal: in_ill, instr: in_instr, pc: in_pc};
   assign out_valid = (state_q != BUF_EMPTY);
   assign in_ready  = in_ready_q;
   assign push      = in_valid && in_ready_q;
   assign pop       = out_valid && out_ready;

   // Next state and entry movement; flush empties the buffer and drops any incoming beat.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = BUF_EMPTY;
      end else begin
         case (state_q)
            BUF_EMPTY: begin
               if (push) begin
                  head_d  = in_beat;
                  state_d = BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (push && pop) begin
                  head_d = in_beat;
               end else if (push) begin
                  skid_d  = in_beat;
                  state_d = BUF_TWO;
               end else if (pop) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_TWO: begin
               if (pop) begin
                  head_d  = skid_q;
                  state_d = BUF_ONE;
               end
            end
            default: state_d = BUF_EMPTY;
         endcase
      end
      in_ready_d = (state_d != BUF_TWO);
   end

   // State, entries and in_ready register; reset wins over flush and handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BUF_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign R       = head_q.str[IT_R]   & out_valid;
   assign I       = head_q.str[IT_I]   & out_valid;
   assign L       = head_q.str[IT_L]   & out_valid;
   assign S       = head_q.str[IT_S]   & out_valid;
   assign B       = head_q.str[IT_B]   & out_valid;
   assign J       = head_q.str[IT_J]   & out_valid;
   assign Jr      = head_q.str[IT_JR]  & out_valid;
   assign lui     = head_q.str[IT_LUI] & out_valid;
   assign aui     = head_q.str[IT_AUI] & out_valid;
   assign illegal = head_q.illegal     & out_valid;

   assign rd        = head_q.instr[11:7];
   assign rs1       = head_q.instr[19:15];
   assign rs2       = head_q.instr[24:20];
   assign func3     = head_q.instr[14:12];
   assign func7     = head_q.instr[31:25];
   assign out_instr = head_q.instr;
   assign out_pc    = head_q.pc;

endmodule

// File: tb/tb_instr_type_decode.sv
// Self-checking bench for instr_type_decode: vector table, corner sequences, random run vs queue model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: exercised via held out_ready=0 sequences and random out_ready.
module tb_instr_type_decode;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_instr, out_pc;
   logic        R, I, L, S, B, J, Jr, lui, aui, illegal;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  func3;
   logic [6:0]  func7;

   always #5 clk = ~clk;

   instr_type_decode dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .R(R), .I(I), .L(L), .S(S), .B(B), .J(J), .Jr(Jr), .lui(lui), .aui(aui),
      .illegal(illegal), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7),
      .out_instr(out_instr), .out_pc(out_pc)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: opcode list in strobe order R,I,L,S,B,J,Jr,lui,aui; result {illegal, strobes}.
   logic [6:0] ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   function automatic logic [9:0] ref_decode(input logic [31:0] w);
      logic [9:0] r;
      r = 10'h200;
      for (int k = 0; k < 9; k++)
         if (w[6:0] == ops[k]) r = 10'(1) << k;
      if (w[1:0] != 2'b11) r = 10'h200;
      return r;
   endfunction

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } mbeat_t;

   mbeat_t mq[$];
   logic   m_rdy = 1'b0;

   function automatic logic [9:0] got_type();
      return {illegal, aui, lui, Jr, J, B, S, L, I, R};
   endfunction

   // One clock: advance the queue model with the current inputs, then compare.
   task automatic cycle();
      logic   p, q, rst_s, fl_s;
      mbeat_t nb;
      p     = in_valid && m_rdy;
      q     = (mq.size() > 0) && out_ready;
      rst_s = rst;
      fl_s  = flush;
      nb    = '{instr: in_instr, pc: in_pc};
      @(posedge clk);
      if (rst_s) begin
         mq.delete();
         m_rdy = 1'b0;
      end else if (fl_s) begin
         mq.delete();
         m_rdy = 1'b1;
      end else begin
         if (q) void'(mq.pop_front());
         if (p) mq.push_back(nb);
         m_rdy = (mq.size() < 2);
      end
      #1;
      check("in_ready", in_ready, m_rdy);
      check("out_valid", out_valid, mq.size() > 0);
      if (rst_s) begin
         check("rst_type", got_type(), 10'h000);
         check("rst_fields", {rd, rs1, rs2, func3, func7}, 64'h0);
         check("rst_instr", out_instr, 32'h0);
         check("rst_pc", out_pc, 32'h0);
      end else if (mq.size() > 0) begin
         check("type", got_type(), ref_decode(mq[0].instr));
         check("out_instr", out_instr, mq[0].instr);
         check("out_pc", out_pc, mq[0].pc);
         check("fields", {rd, rs1, rs2, func3, func7},
               {mq[0].instr[11:7], mq[0].instr[19:15], mq[0].instr[24:20],
                mq[0].instr[14:12], mq[0].instr[31:25]});
      end else begin
         check("idle_type", got_type(), 10'h000);
      end
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [9:0]  exp_type;
   } vec_t;

   vec_t tab [11];

   initial begin
      tab[0]  = '{32'h00500093, 10'h002};  // addi -> I
      tab[1]  = '{32'h12345137, 10'h080};  // lui
      tab[2]  = '{32'h00000517, 10'h100};  // auipc
      tab[3]  = '{32'h0000006F, 10'h020};  // jal
      tab[4]  = '{32'h00008067, 10'h040};  // jalr
      tab[5]  = '{32'h00112023, 10'h008};  // sw
      tab[6]  = '{32'h00208463, 10'h010};  // beq
      tab[7]  = '{32'h0000A083, 10'h004};  // lw
      tab[8]  = '{32'h002081B3, 10'h001};  // add
      tab[9]  = '{32'h00000000, 10'h200};  // illegal
      tab[10] = '{32'hFFFFFFFF, 10'h200};  // illegal

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      in_instr = '0; in_pc = '0;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      check("ready_after_rst", in_ready, 1'b1);

      // Back-to-back vectors: each beat shows up the cycle after it is taken.
      in_valid = 1'b1;
      for (int i = 0; i < 11; i++) begin
         in_instr = tab[i].instr;
         in_pc    = 32'h1000 + 32'(i * 4);
         cycle();
         check("vec_type", got_type(), tab[i].exp_type);
         check("vec_valid", out_valid, 1'b1);
         if (i == 0) check("addi_fields", {rd, rs1, func3}, {5'd1, 5'd0, 3'd0});
      end
      in_valid = 1'b0;
      cycle();
      check("drained", out_valid, 1'b0);

      // Backpressure: three offers with out_ready low.
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00100093; in_pc = 32'h100; cycle();
      in_instr = 32'h00200113; in_pc = 32'h104; cycle();
      check("bp_ready_low", in_ready, 1'b0);
      in_instr = 32'h00300193; in_pc = 32'h108; cycle();
      check("bp_hold1", out_instr, 32'h00100093);
      cycle();
      check("bp_hold2", out_instr, 32'h00100093);
      out_ready = 1'b1;
      cycle();
      check("bp_beat2", out_instr, 32'h00200113);
      cycle();
      check("bp_beat3", out_instr, 32'h00300193);
      in_valid = 1'b0;
      cycle();
      check("bp_empty", out_valid, 1'b0);

      // Flush with two held beats and a new beat offered.
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00400213; cycle();
      in_instr = 32'h00500293; cycle();
      flush = 1'b1; in_instr = 32'h00600313; cycle();
      check("flush_valid", out_valid, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         cycle();
         check("flush_gone", out_valid, 1'b0);
      end

      // Flush from one held beat while in_ready is high: offered beat still dropped.
      in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'h00700393; cycle();
      flush = 1'b1; in_instr = 32'h00800413; cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cycle();
      check("flush1_gone", out_valid, 1'b0);

      // Reset with two beats held.
      out_ready = 1'b0; in_valid = 1'b1;
      in_instr = 32'h00900493; in_pc = 32'h200; cycle();
      in_instr = 32'h00A00513; in_pc = 32'h204; cycle();
      rst = 1'b1; in_valid = 1'b0; cycle();
      check("rstmid_valid", out_valid, 1'b0);
      check("rstmid_instr", out_instr, 32'h0);
      rst = 1'b0; out_ready = 1'b1; cycle();
      check("rstmid_ready", in_ready, 1'b1);

      // Random traffic against the queue model.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] w;
         w = $urandom();
         if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 8)];
         in_instr  = w;
         in_pc     = $urandom();
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 29) == 0);
         rst       = ($urandom_range(0, 79) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
